// File: rtl/change_dispenser.sv
// change_dispenser: pays out a change amount as a greedy sequence of coins,
// offered one at a time to the coin ejector over a valid/ack handshake.
// Optional feature macro: JAM_DETECT_EN. When it is defined, a coin left
// unacknowledged for ACK_TIMEOUT cycles withdraws the offer and parks the
// block in FAULT, and only reset leaves FAULT. When it is undefined, the
// block waits for an ack indefinitely and fault is tied low.
module change_dispenser #(
    parameter int unsigned COIN_A      = 10,
    parameter int unsigned COIN_B      = 5,
    parameter int unsigned COIN_C      = 2,
    parameter int unsigned COIN_D      = 1,
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       startDispense,
    input  logic [4:0] changeAmount,
    input  logic       coinAck,
    output logic       coinValid,
    output logic [1:0] coinType,
    output logic [4:0] remaining,
    output logic [4:0] coinCount,
    output logic       busy,
    output logic       done,
    output logic       fault
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] SELECT = 3'd1;
    localparam logic [2:0] OFFER  = 3'd2;
    localparam logic [2:0] DONE   = 3'd3;
    localparam logic [2:0] FAULT  = 3'd4;

    // Denominations are compared as unsigned 5-bit values.
    localparam logic [4:0] DENOM_A = 5'(COIN_A);
    localparam logic [4:0] DENOM_B = 5'(COIN_B);
    localparam logic [4:0] DENOM_C = 5'(COIN_C);
    localparam logic [4:0] DENOM_D = 5'(COIN_D);

    // Greedy decomposition only works with a strictly descending set ending in 1.
    if (COIN_D != 1 || COIN_A > 31 || !(COIN_A > COIN_B && COIN_B > COIN_C && COIN_C > COIN_D))
    begin : g_badDenom
        $error("change_dispenser: denominations must be descending, <=31, with COIN_D == 1");
    end
    if (ACK_TIMEOUT < 1 || ACK_TIMEOUT > 255) begin : g_badTimeout
        $error("change_dispenser: ACK_TIMEOUT must be in 1..255");
    end

    logic [2:0] stateReg;
    logic       coinValidReg;
    logic [1:0] coinTypeReg;
    logic [4:0] remainingReg;
    logic [4:0] coinCountReg;
    logic       busyReg;
    logic       doneReg;
    logic [4:0] denomValue [4];
    logic [3:0] denomFits;
    logic [1:0] selIdx;

    assign denomValue[0] = DENOM_A;
    assign denomValue[1] = DENOM_B;
    assign denomValue[2] = DENOM_C;
    assign denomValue[3] = DENOM_D;

    for (genvar gi = 0; gi < 4; gi++) begin : g_fit
        assign denomFits[gi] = (denomValue[gi] <= remainingReg);
    end

    // Pick the largest denomination that still fits (lowest index wins).
    always_comb begin
        selIdx = 2'd3;
        for (int i = 3; i >= 0; i--) begin
            if (denomFits[i]) selIdx = 2'(i);
        end
    end

`ifdef JAM_DETECT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(ACK_TIMEOUT - 1);
    logic [7:0] ackTimerReg;
    logic       faultReg;
    assign fault = faultReg;
`else
    assign fault = 1'b0;
`endif

    // Main sequencer: every output is a register updated here.
    always_ff @(posedge clock) begin
        if (!reset) begin
            stateReg     <= IDLE;
            coinValidReg <= 1'b0;
            coinTypeReg  <= 2'd0;
            remainingReg <= 5'd0;
            coinCountReg <= 5'd0;
            busyReg      <= 1'b0;
            doneReg      <= 1'b0;
`ifdef JAM_DETECT_EN
            ackTimerReg  <= 8'd0;
            faultReg     <= 1'b0;
`endif
        end else begin
            doneReg <= 1'b0;
            case (stateReg)
                IDLE: begin
                    if (startDispense) begin
                        remainingReg <= changeAmount;
                        coinCountReg <= 5'd0;
                        busyReg      <= 1'b1;
                        stateReg     <= SELECT;
                    end
                end
                SELECT: begin
                    if (remainingReg == 5'd0) begin
                        stateReg <= DONE;
                    end else begin
                        coinTypeReg  <= selIdx;
                        coinValidReg <= 1'b1;
                        stateReg     <= OFFER;
`ifdef JAM_DETECT_EN
                        ackTimerReg  <= 8'd0;
`endif
                    end
                end
                OFFER: begin
                    // An ack always beats a timeout landing in the same cycle.
                    if (coinAck && coinValidReg) begin
                        coinValidReg <= 1'b0;
                        remainingReg <= remainingReg - denomValue[coinTypeReg];
                        if (coinCountReg != 5'd31) coinCountReg <= coinCountReg + 5'd1;
                        stateReg     <= SELECT;
                    end
`ifdef JAM_DETECT_EN
                    else if (ackTimerReg == TIMEOUT_LAST) begin
                        coinValidReg <= 1'b0;
                        faultReg     <= 1'b1;
                        stateReg     <= FAULT;
                    end else begin
                        ackTimerReg <= ackTimerReg + 8'd1;
                    end
`endif
                end
                DONE: begin
                    doneReg  <= 1'b1;
                    busyReg  <= 1'b0;
                    stateReg <= IDLE;
                end
                FAULT: begin
                    // Frozen until reset; busy stays high.
                    stateReg <= FAULT;
                end
                default: begin
                    coinValidReg <= 1'b0;
                    busyReg      <= 1'b0;
                    stateReg     <= IDLE;
                end
            endcase
        end
    end

    assign coinValid = coinValidReg;
    assign coinType  = coinTypeReg;
    assign remaining = remainingReg;
    assign coinCount = coinCountReg;
    assign busy      = busyReg;
    assign done      = doneReg;

endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: directed bench for change_dispenser. Expected coin
// types are queued when a payout starts and popped as each coin is offered.
module tb_change_dispenser;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       startDispense = 1'b0;
    logic [4:0] changeAmount = 5'd0;
    logic       coinAck = 1'b0;
    logic       coinValid;
    logic [1:0] coinType;
    logic [4:0] remaining;
    logic [4:0] coinCount;
    logic       busy;
    logic       done;
    logic       fault;

    int total = 0;
    int bad = 0;
    logic [1:0] expQ[$];

    change_dispenser #(
        .COIN_A(10), .COIN_B(5), .COIN_C(2), .COIN_D(1), .ACK_TIMEOUT(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .startDispense(startDispense),
        .changeAmount(changeAmount),
        .coinAck(coinAck),
        .coinValid(coinValid),
        .coinType(coinType),
        .remaining(remaining),
        .coinCount(coinCount),
        .busy(busy),
        .done(done),
        .fault(fault)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Run one payout, popping expected coin types from expQ as coins appear.
    task automatic payout(input logic [4:0] amount, input int ackDelay, input bit tieAck,
                          input bit poke, input logic [4:0] expCount, input string name);
        int waitCyc;
        int doneSeen;
        logic [1:0] want;
        coinAck = tieAck;
        changeAmount = amount;
        startDispense = 1'b1;
        step();
        startDispense = 1'b0;
        changeAmount = 5'd0;
        chk({name, "_busy"}, busy, 1);
        while (expQ.size() > 0) begin
            waitCyc = 0;
            while (!coinValid && waitCyc < 8) begin
                step();
                waitCyc++;
            end
            if (!coinValid) begin
                chk({name, "_coinwait"}, coinValid, 1);
                expQ.delete();
                break;
            end
            want = expQ.pop_front();
            chk({name, "_type"}, coinType, want);
            for (int d = 0; d < ackDelay; d++) begin
                if (poke && d == 0) begin
                    startDispense = 1'b1;
                    changeAmount = 5'd9;
                end
                step();
                startDispense = 1'b0;
                changeAmount = 5'd0;
                chk({name, "_holdvalid"}, coinValid, 1);
                chk({name, "_holdtype"}, coinType, want);
            end
            coinAck = 1'b1;
            step();
            coinAck = tieAck;
            chk({name, "_dropvalid"}, coinValid, 0);
        end
        doneSeen = 0;
        for (int c = 0; c < 6; c++) begin
            if (done) doneSeen++;
            chk({name, "_nocoin"}, coinValid, 0);
            step();
        end
        chk({name, "_donecount"}, doneSeen, 1);
        chk({name, "_remaining"}, remaining, 0);
        chk({name, "_count"}, coinCount, expCount);
        chk({name, "_busyend"}, busy, 0);
        coinAck = 1'b0;
    endtask

    initial begin
        // Reset state
        step();
        step();
        reset = 1'b1;
        chk("rst_valid", coinValid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_remaining", remaining, 0);
        chk("rst_fault", fault, 0);

        // Reset mid-OFFER, amount 7: first coin is a 5
        changeAmount = 5'd7;
        startDispense = 1'b1;
        step();
        startDispense = 1'b0;
        step();
        chk("mid_valid", coinValid, 1);
        chk("mid_type", coinType, 1);
        chk("mid_remaining", remaining, 7);
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("midrst_valid", coinValid, 0);
        chk("midrst_type", coinType, 0);
        chk("midrst_remaining", remaining, 0);
        chk("midrst_count", coinCount, 0);
        chk("midrst_busy", busy, 0);
        coinAck = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("ignack_valid", coinValid, 0);
            chk("ignack_busy", busy, 0);
            chk("ignack_remaining", remaining, 0);
        end
        coinAck = 1'b0;

        // Amount 18 with ack tied high: 10+5+2+1
        expQ.push_back(2'd0); expQ.push_back(2'd1); expQ.push_back(2'd2); expQ.push_back(2'd3);
        payout(5'd18, 0, 1'b1, 1'b0, 5'd4, "amt18");

        // Amount 31 with 3-cycle ack delay: 10+10+10+1
        expQ.push_back(2'd0); expQ.push_back(2'd0); expQ.push_back(2'd0); expQ.push_back(2'd3);
        payout(5'd31, 3, 1'b0, 1'b0, 5'd4, "amt31");

        // Amount 0: done exactly two edges after the start edge, no coin
        changeAmount = 5'd0;
        startDispense = 1'b1;
        step();
        startDispense = 1'b0;
        chk("zero_busy", busy, 1);
        chk("zero_done_n", done, 0);
        step();
        chk("zero_done_n1", done, 0);
        chk("zero_valid", coinValid, 0);
        step();
        chk("zero_done_n2", done, 1);
        chk("zero_busyend", busy, 0);
        chk("zero_count", coinCount, 0);
        step();
        chk("zero_donepulse", done, 0);

        // Amount 6 with a second start (amount 9) mid-payout: ignored
        expQ.push_back(2'd1); expQ.push_back(2'd3);
        payout(5'd6, 2, 1'b0, 1'b1, 5'd2, "amt6");

`ifdef JAM_DETECT_EN
        // Never ack: offer withdrawn after 4 OFFER cycles, fault latched
        changeAmount = 5'd12;
        startDispense = 1'b1;
        step();
        startDispense = 1'b0;
        step();
        chk("jam_valid_c1", coinValid, 1);
        step(); step(); step();
        chk("jam_valid_c4", coinValid, 1);
        chk("jam_fault_c4", fault, 0);
        step();
        chk("jam_valid_drop", coinValid, 0);
        chk("jam_fault", fault, 1);
        chk("jam_busy", busy, 1);
        chk("jam_remaining", remaining, 12);
        step();
        chk("jam_fault_hold", fault, 1);
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("jam_rst_fault", fault, 0);

        // Ack on the 4th OFFER cycle wins over the timeout
        changeAmount = 5'd12;
        startDispense = 1'b1;
        step();
        startDispense = 1'b0;
        step(); step(); step(); step();
        chk("jamack_valid_c4", coinValid, 1);
        coinAck = 1'b1;
        step();
        coinAck = 1'b0;
        chk("jamack_fault", fault, 0);
        chk("jamack_remaining", remaining, 2);
        chk("jamack_count", coinCount, 1);
        reset = 1'b0;
        step();
        reset = 1'b1;
`else
        chk("nojam_fault", fault, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Sequences the physical coin ejector so it pays out a change amount once the main state machine has settled the transaction.
- Takes a one-cycle start strobe and a 5-bit amount in money units, from the change calculator output.
- Decomposes the amount greedily into coins of four fixed denominations and offers them one at a time over a valid/ack handshake.
- Sits between the change calculator and the coin ejector; reports busy and done back to the main state machine.

Parameters:
- COIN_A, 10, largest denomination in units.
- COIN_B, 5, second denomination.
- COIN_C, 2, third denomination.
- COIN_D, 1, smallest denomination. Must equal 1 so any amount is payable. Ordering COIN_A > COIN_B > COIN_C > COIN_D is mandatory.
- ACK_TIMEOUT, 15, cycles coinValid may stay unacknowledged before fault; range 1..255. Used only with JAM_DETECT_EN.

Ports:
- clock  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-low reset (reset==0 sampled at posedge resets the block)
- startDispense  input  1  one-cycle strobe: begin paying changeAmount
- changeAmount  input  5  amount to pay, 0..31 units; sampled only with startDispense in IDLE
- coinAck  input  1  ejector accepted the offered coin
- coinValid  output  1  a coin is offered on coinType
- coinType  output  2  0=COIN_A, 1=COIN_B, 2=COIN_C, 3=COIN_D; stable while coinValid
- remaining  output  5  units still to pay
- coinCount  output  5  coins ejected in current transaction, saturates at 31
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse when the transaction completes
- fault  output  1  high in FAULT (JAM_DETECT_EN only, else tied 0)

Behaviour:
- Reset values (reset==0 at posedge):
  - state=IDLE.
  - coinValid=0, coinType=0, remaining=0, coinCount=0, busy=0, done=0, fault=0.
  - Reset overrides everything, including mid-handshake; a coin offered but not acked is abandoned.
- States: IDLE, SELECT, OFFER, DONE, FAULT. All outputs are registered.
- IDLE:
  - On startDispense: remaining<=changeAmount, coinCount<=0, go SELECT.
  - Amount 0 is legal: it passes through SELECT to DONE.
- SELECT (one cycle):
  - If remaining==0, go DONE.
  - Otherwise coinType<=index of the largest denomination <= remaining, coinValid<=1, go OFFER.
- OFFER:
  - coinValid held high and coinType held stable until coinAck==1 is sampled while coinValid==1.
  - On transfer: coinValid<=0, remaining<=remaining-denom, coinCount<=coinCount+1 (saturating), go SELECT.
  - Only one coin per transfer; minimum 2 cycles per coin.
  - coinAck is ignored whenever coinValid==0.
- DONE: done=1 for exactly one cycle, then IDLE. remaining=0 and coinCount hold until the next start.
- startDispense outside IDLE is ignored; no queuing.
- Latency:
  - start at edge N: SELECT after N, coinValid=1 after N+1.
  - Zero-amount start: done=1 after N+2.
- Arithmetic:
  - remaining never underflows, because SELECT only picks denom <= remaining.
  - All comparisons are unsigned 5-bit; parameters are compared after zero-extension.

Optional Feature:
- JAM_DETECT_EN defined:
  - 8-bit timeout counter cleared on entering OFFER, incremented each OFFER cycle without ack.
  - When it reaches ACK_TIMEOUT with no ack: coinValid<=0, go FAULT.
  - FAULT: fault=1, busy=1, remaining and coinCount frozen. Exit only via reset.
  - An ack in the same cycle as the timeout wins; the transfer completes, no fault.
- JAM_DETECT_EN undefined: no counter; OFFER waits indefinitely; fault is constant 0.

Test Plan:
- Reset with outputs driven mid-OFFER (amount 7) -> next cycle all outputs 0, state IDLE; coinAck then ignored.
- start, amount=18, coinAck tied 1 -> coinType sequence 0,1,2,3 (10+5+2+1), coinCount=4, remaining=0, done pulse once, busy low after done.
- start, amount=31, coinAck delayed 3 cycles per coin -> coinType 0,0,0,3; coinType stable while waiting; coinCount=4.
- start, amount=0 -> no coinValid; done pulses 2 cycles after the start edge.
- startDispense re-asserted with amount=9 during the amount=6 payout -> ignored; coins 5,1 only; remaining ends 0.
- JAM_DETECT_EN, ACK_TIMEOUT=4, amount=12, coinAck never asserted -> coinValid drops after 4 OFFER cycles, fault=1, remaining=12; ack on the 4th cycle instead -> no fault, remaining=2.
